// File: rtl/hazard_sequencer_if.sv
// Hazard-unit bus between the pipeline datapath and the hazard sequencer.
// The datapath side (master) supplies register-match and stage status; the sequencer (slave) returns the controls.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Match_1E_M;
    logic             Match_2E_M;
    logic             Match_1E_W;
    logic             Match_2E_W;
    logic             Match_12D_E;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             PCWrPendingF;
    logic             PCSrcW;
    logic             BranchTakenE;
    logic             MulStartE;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             MulBusy;
    logic             MulDone;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Match_1E_M, Match_2E_M, Match_1E_W, Match_2E_W, Match_12D_E,
               RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW,
               BranchTakenE, MulStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulBusy, MulDone, StallCount
    );

    modport slave (
        input  Match_1E_M, Match_2E_M, Match_1E_W, Match_2E_W, Match_12D_E,
               RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW,
               BranchTakenE, MulStartE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulBusy, MulDone, StallCount
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard control for the 5-stage core: forwarding selects, load-use stall, branch/PC-write flushes,
// multi-cycle multiply sequencing in Execute, and a saturating stall-cycle counter.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no multiply in flight; a MulStartE begins one (or completes it if MUL_CYCLES==1)
// BUSY  | multiply held in Execute; cnt counts remaining stall cycles, cnt==0 is the final cycle
module hazard_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_sequencer_if.slave   hz
);

    localparam int              CW        = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam bit              MUL_MULTI = (MUL_CYCLES > 1);
    // Start cycle is one occupancy cycle and the cnt==0 cycle is another, hence the -2.
    localparam logic [CW-1:0]   CNT_LOAD  = MUL_MULTI ? CW'(MUL_CYCLES - 2) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    mul_state_t        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              mul_stall;
    logic              mul_done;
    logic              ldr_stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall_f;
    logic [CNT_W-1:0]  stall_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MulStartE is ignored while BUSY: the same multiply is still being held in Execute.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        case (state)
            IDLE: begin
                if (hz.MulStartE) begin
                    if (MUL_MULTI) begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                        mul_stall = 1'b1;
                    end else begin
                        mul_done  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt   = cnt - CW'(1);
                    mul_stall = 1'b1;
                end else begin
                    mul_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ldr_stall = hz.Match_12D_E & hz.MemtoRegE;

    // Memory-stage result is younger than Writeback, so it takes precedence.
    always_comb begin
        fwd_a = 2'b00;
        if (hz.Match_1E_M && hz.RegWriteM)
            fwd_a = 2'b10;
        else if (hz.Match_1E_W && hz.RegWriteW)
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (hz.Match_2E_M && hz.RegWriteM)
            fwd_b = 2'b10;
        else if (hz.Match_2E_W && hz.RegWriteW)
            fwd_b = 2'b01;
    end

    assign stall_f = reset & (ldr_stall | hz.PCWrPendingF | mul_stall);

    // Combinational controls are gated so nothing leaks out while reset is asserted.
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushM    = 1'b0;
        hz.MulDone   = 1'b0;
        if (reset) begin
            hz.ForwardAE = fwd_a;
            hz.ForwardBE = fwd_b;
            hz.StallF    = stall_f;
            hz.StallD    = ldr_stall | mul_stall;
            hz.StallE    = mul_stall;
            hz.FlushD    = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
            hz.FlushE    = ldr_stall | hz.BranchTakenE;
            hz.FlushM    = mul_stall;
            hz.MulDone   = mul_done;
        end
    end

    assign hz.MulBusy = (state == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall_f && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

    assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (MUL_CYCLES=4, CNT_W=4): forwarding, load-use,
// flushes, multiply timing, reset abort and stall-counter saturation.
module tb_hazard_sequencer;

    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    hazard_sequencer_if #(.CNT_W(CNT_W)) hif ();

    hazard_sequencer #(.MUL_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.Match_1E_M   = 1'b0;
        hif.Match_2E_M   = 1'b0;
        hif.Match_1E_W   = 1'b0;
        hif.Match_2E_W   = 1'b0;
        hif.Match_12D_E  = 1'b0;
        hif.RegWriteM    = 1'b0;
        hif.RegWriteW    = 1'b0;
        hif.MemtoRegE    = 1'b0;
        hif.PCWrPendingF = 1'b0;
        hif.PCSrcW       = 1'b0;
        hif.BranchTakenE = 1'b0;
        hif.MulStartE    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        clear_inputs();

        // Reset: requests present but every control held low
        hif.Match_1E_M  = 1'b1;
        hif.RegWriteM   = 1'b1;
        hif.MemtoRegE   = 1'b1;
        hif.Match_12D_E = 1'b1;
        #1;
        chk("rst_fwda",   16'(hif.ForwardAE),  16'h0);
        chk("rst_stallf", 16'(hif.StallF),     16'h0);
        chk("rst_flushe", 16'(hif.FlushE),     16'h0);
        chk("rst_busy",   16'(hif.MulBusy),    16'h0);
        chk("rst_cnt",    16'(hif.StallCount), 16'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_cnt_hold", 16'(hif.StallCount), 16'h0);
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("idle_stallf", 16'(hif.StallF), 16'h0);

        // Forwarding
        @(negedge clk);
        hif.Match_1E_M = 1'b1; hif.Match_1E_W = 1'b1;
        hif.RegWriteM  = 1'b1; hif.RegWriteW  = 1'b1;
        #1;
        chk("fwd_a_mem",  16'(hif.ForwardAE), 16'h2);
        chk("fwd_b_none", 16'(hif.ForwardBE), 16'h0);
        hif.RegWriteM = 1'b0;
        #1;
        chk("fwd_a_wb", 16'(hif.ForwardAE), 16'h1);
        hif.RegWriteW = 1'b0;
        #1;
        chk("fwd_a_none", 16'(hif.ForwardAE), 16'h0);
        hif.Match_2E_W = 1'b1; hif.RegWriteW = 1'b1;
        #1;
        chk("fwd_b_wb", 16'(hif.ForwardBE), 16'h1);
        hif.Match_2E_M = 1'b1; hif.RegWriteM = 1'b1;
        #1;
        chk("fwd_b_mem", 16'(hif.ForwardBE), 16'h2);
        chk("fwd_a_mem2", 16'(hif.ForwardAE), 16'h2);
        chk("fwd_nostall", 16'(hif.StallF), 16'h0);
        clear_inputs();

        // Load-use, one cycle
        @(negedge clk);
        hif.MemtoRegE = 1'b1;
        #1;
        chk("ld_only_nostall", 16'(hif.StallF), 16'h0);
        hif.Match_12D_E = 1'b1;
        #1;
        chk("ld_stallf", 16'(hif.StallF), 16'h1);
        chk("ld_stalld", 16'(hif.StallD), 16'h1);
        chk("ld_flushe", 16'(hif.FlushE), 16'h1);
        chk("ld_stalle", 16'(hif.StallE), 16'h0);
        chk("ld_flushd", 16'(hif.FlushD), 16'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("ld_cnt", 16'(hif.StallCount), 16'h1);
        chk("ld_release", 16'(hif.StallF), 16'h0);

        // Taken branch, PC write pending, PC write commit
        @(negedge clk);
        hif.BranchTakenE = 1'b1;
        #1;
        chk("br_flushd", 16'(hif.FlushD), 16'h1);
        chk("br_flushe", 16'(hif.FlushE), 16'h1);
        chk("br_stallf", 16'(hif.StallF), 16'h0);
        @(negedge clk);
        clear_inputs();
        hif.PCWrPendingF = 1'b1;
        #1;
        chk("pcw_stallf", 16'(hif.StallF), 16'h1);
        chk("pcw_flushd", 16'(hif.FlushD), 16'h1);
        chk("pcw_stalld", 16'(hif.StallD), 16'h0);
        chk("pcw_flushe", 16'(hif.FlushE), 16'h0);
        @(negedge clk);
        clear_inputs();
        hif.PCSrcW = 1'b1;
        #1;
        chk("pcsrc_flushd", 16'(hif.FlushD), 16'h1);
        chk("pcsrc_stallf", 16'(hif.StallF), 16'h0);
        chk("pcw_cnt", 16'(hif.StallCount), 16'h2);
        @(negedge clk);
        clear_inputs();

        // Multiply: MulStartE held for the four Execute cycles
        hif.MulStartE = 1'b1;
        #1;
        chk("mul_c0_stalle", 16'(hif.StallE),  16'h1);
        chk("mul_c0_flushm", 16'(hif.FlushM),  16'h1);
        chk("mul_c0_stallf", 16'(hif.StallF),  16'h1);
        chk("mul_c0_busy",   16'(hif.MulBusy), 16'h0);
        chk("mul_c0_done",   16'(hif.MulDone), 16'h0);
        @(negedge clk);
        chk("mul_c1_stalle", 16'(hif.StallE),  16'h1);
        chk("mul_c1_busy",   16'(hif.MulBusy), 16'h1);
        chk("mul_c1_done",   16'(hif.MulDone), 16'h0);
        @(negedge clk);
        chk("mul_c2_stalle", 16'(hif.StallE),  16'h1);
        chk("mul_c2_busy",   16'(hif.MulBusy), 16'h1);
        @(negedge clk);
        chk("mul_c3_stalle", 16'(hif.StallE),  16'h0);
        chk("mul_c3_stallf", 16'(hif.StallF),  16'h0);
        chk("mul_c3_done",   16'(hif.MulDone), 16'h1);
        chk("mul_c3_busy",   16'(hif.MulBusy), 16'h1);
        @(negedge clk);
        hif.MulStartE = 1'b0;
        #1;
        chk("mul_c4_busy", 16'(hif.MulBusy),    16'h0);
        chk("mul_c4_done", 16'(hif.MulDone),    16'h0);
        chk("mul_cnt",     16'(hif.StallCount), 16'h5);

        // Reset during BUSY cycle 2 aborts the multiply
        @(negedge clk);
        hif.MulStartE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_c2_busy", 16'(hif.MulBusy), 16'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_stalle", 16'(hif.StallE),     16'h0);
        chk("abort_stallf", 16'(hif.StallF),     16'h0);
        chk("abort_flushm", 16'(hif.FlushM),     16'h0);
        chk("abort_busy",   16'(hif.MulBusy),    16'h0);
        chk("abort_done",   16'(hif.MulDone),    16'h0);
        chk("abort_cnt",    16'(hif.StallCount), 16'h0);
        @(negedge clk);
        hif.MulStartE = 1'b0;
        reset = 1'b1;
        #1;
        chk("post_rst_stallf", 16'(hif.StallF), 16'h0);
        @(negedge clk);
        chk("post_rst_busy", 16'(hif.MulBusy),    16'h0);
        chk("post_rst_cnt",  16'(hif.StallCount), 16'h0);

        // Stall counter saturation under a 20-cycle load-use hold
        hif.MemtoRegE   = 1'b1;
        hif.Match_12D_E = 1'b1;
        repeat (14) @(negedge clk);
        chk("sat_cnt14", 16'(hif.StallCount), 16'hE);
        repeat (6) @(negedge clk);
        chk("sat_cnt20", 16'(hif.StallCount), 16'hF);
        clear_inputs();
        @(negedge clk);
        chk("sat_hold", 16'(hif.StallCount), 16'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
